// File: rtl/div_unit_pkg.sv
// Shared definitions for the radix-2 restoring divider: ALU function codes,
// divider state encodings and small decode helpers.
package div_unit_pkg;

  // ALU function codes that route to the divider.
  localparam logic [4:0] ALU_DIV  = 5'd16;
  localparam logic [4:0] ALU_DIVU = 5'd17;
  localparam logic [4:0] ALU_REM  = 5'd18;
  localparam logic [4:0] ALU_REMU = 5'd19;

  // Divider controller states.
  typedef enum logic [1:0] {
    DIV_STATE_IDLE = 2'd0,
    DIV_STATE_CALC = 2'd1,
    DIV_STATE_DONE = 2'd2
  } div_state_e;

  // True for any of the four divider function codes.
  function automatic logic is_div_func(input logic [4:0] f);
    return (f == ALU_DIV) || (f == ALU_DIVU) || (f == ALU_REM) || (f == ALU_REMU);
  endfunction

  // True for the signed variants (DIV, REM).
  function automatic logic is_signed_func(input logic [4:0] f);
    return (f == ALU_DIV) || (f == ALU_REM);
  endfunction

  // True when the quotient is the selected result (DIV, DIVU).
  function automatic logic is_quot_func(input logic [4:0] f);
    return (f == ALU_DIV) || (f == ALU_DIVU);
  endfunction

  // Magnitude of a signed operand; raw value when the operation is unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_sign_fixup.sv
// Sign fix-up and result select for the divider: applies two's-complement
// negation to the raw magnitude quotient/remainder and picks the one the
// function code asks for. Purely combinational.
module div_sign_fixup
  import div_unit_pkg::*;
(
  input  logic [31:0] quot_raw_i,
  input  logic [31:0] rem_raw_i,
  input  logic        quot_neg_i,
  input  logic        rem_neg_i,
  input  logic [4:0]  func_i,
  output logic [31:0] result_o
);

  logic [31:0] quot_fixed;
  logic [31:0] rem_fixed;

  // Negate where required, then select quotient or remainder.
  always_comb begin
    quot_fixed = quot_neg_i ? (~quot_raw_i + 32'd1) : quot_raw_i;
    rem_fixed  = rem_neg_i  ? (~rem_raw_i  + 32'd1) : rem_raw_i;
    result_o   = is_quot_func(func_i) ? quot_fixed : rem_fixed;
  end

endmodule

// File: rtl/div_unit.sv
// div_unit: 32-bit multi-cycle restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle; 33 cycles from accepted start to done.
// Optional build macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow
// complete straight from IDLE with a 1-cycle latency.
module div_unit
  import div_unit_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        flush,
  input  logic [4:0]  alu_function,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  div_state_e  state_q;
  logic [4:0]  func_q;
  logic [31:0] dvd_q;      // dividend bits shift out the top, quotient bits in the bottom
  logic [31:0] rem_q;      // partial remainder
  logic [31:0] dvs_q;      // divisor magnitude
  logic        quot_neg_q;
  logic        rem_neg_q;
  logic [4:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] result_q;

  logic [32:0] partial;
  logic [32:0] diff;
  logic [31:0] rem_d;
  logic [31:0] dvd_d;
  logic [31:0] fixed_result;
  logic        op_signed;

  assign op_signed = is_signed_func(alu_function);

`ifdef DIV_EARLY_OUT_EN
  logic        div_by_zero;
  logic        signed_ovf;
  logic [31:0] early_result;

  // Detect the two corner cases at the start edge and form their results.
  always_comb begin
    div_by_zero  = (operand_b == 32'd0);
    signed_ovf   = op_signed && (operand_a == 32'h8000_0000) && (operand_b == 32'hFFFF_FFFF);
    early_result = 32'd0;
    if (is_quot_func(alu_function)) begin
      early_result = div_by_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
    end else begin
      early_result = div_by_zero ? operand_a : 32'd0;
    end
  end
`endif

  // One restoring step: trial-subtract the divisor from the shifted remainder.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    rem_d   = {rem_q[30:0], dvd_q[31]};
    dvd_d   = {dvd_q[30:0], 1'b0};
    partial = {rem_q, dvd_q[31]};
    diff    = partial - {1'b0, dvs_q};
    // rem_q < dvs_q always holds, so diff fits in 33 signed bits and diff[32] is its sign.
    if (!diff[32]) begin
      rem_d = diff[31:0];
      dvd_d = {dvd_q[30:0], 1'b1};
    end
  end

  // Fix-up sees the final iteration's values so result is written on the CALC->DONE edge.
  div_sign_fixup u_fixup (
    .quot_raw_i (dvd_d),
    .rem_raw_i  (rem_d),
    .quot_neg_i (quot_neg_q),
    .rem_neg_i  (rem_neg_q),
    .func_i     (func_q),
    .result_o   (fixed_result)
  );

  // Controller, counter and shift datapath with registered busy/done/result.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state_q    <= DIV_STATE_IDLE;
      func_q     <= 5'd0;
      dvd_q      <= 32'd0;
      rem_q      <= 32'd0;
      dvs_q      <= 32'd0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      cnt_q      <= 5'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= 32'd0;
    end else if (flush) begin
      state_q <= DIV_STATE_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        DIV_STATE_IDLE: begin
          if (start && is_div_func(alu_function)) begin
            func_q    <= alu_function;
            dvd_q     <= mag32(operand_a, op_signed);
            dvs_q     <= mag32(operand_b, op_signed);
            rem_q     <= 32'd0;
            // A zero divisor yields an all-ones magnitude quotient that must not be negated.
            quot_neg_q <= op_signed && (operand_a[31] ^ operand_b[31]) && (operand_b != 32'd0);
            rem_neg_q <= op_signed && operand_a[31];
            cnt_q     <= 5'd31;
            busy_q    <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
            if (div_by_zero || signed_ovf) begin
              state_q  <= DIV_STATE_DONE;
              result_q <= early_result;
              done_q   <= 1'b1;
            end else begin
              state_q  <= DIV_STATE_CALC;
            end
`else
            state_q   <= DIV_STATE_CALC;
`endif
          end
        end
        DIV_STATE_CALC: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          if (cnt_q == 5'd0) begin
            state_q  <= DIV_STATE_DONE;
            result_q <= fixed_result;
            done_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        DIV_STATE_DONE: begin
          state_q <= DIV_STATE_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= DIV_STATE_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  alu_function = ALU_DIV;
  logic [31:0] operand_a = 32'd0;
  logic [31:0] operand_b = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  div_unit dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .flush        (flush),
    .alu_function (alu_function),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .busy         (busy),
    .done         (done),
    .result       (result)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // RISC-V M-extension division semantics in plain arithmetic.
  function automatic logic [31:0] ref_result(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    logic want_q;
    logic sgn;
    want_q = (f == ALU_DIV) || (f == ALU_DIVU);
    sgn    = (f == ALU_DIV) || (f == ALU_REM);
    if (b == 32'd0) return want_q ? 32'hFFFF_FFFF : a;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return want_q ? 32'h8000_0000 : 32'd0;
    if (sgn) return want_q ? 32'($signed(a) / $signed(b)) : 32'($signed(a) % $signed(b));
    return want_q ? (a / b) : (a % b);
  endfunction

  // Clock edges between the start edge and the first cycle with done high.
  function automatic int ref_edges(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    if (b == 32'd0) return 0;
    if (((f == ALU_DIV) || (f == ALU_REM)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
`endif
    return 32;
  endfunction

  // Issue one operation and check latency, busy, result hold and final result.
  task automatic run_op(input string tag, input logic [4:0] f, input logic [31:0] a,
                        input logic [31:0] b, input bit poke);
    logic [31:0] prev;
    int n;
    bit busy_ok;
    bit hold_ok;
    prev = result;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    alu_function = f;
    operand_a = a;
    operand_b = b;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 40) begin
      if (result !== prev) hold_ok = 1'b0;
      if (poke && n == 4) begin
        start = 1'b1;
        alu_function = ALU_DIVU;
        operand_a = $urandom;
        operand_b = $urandom | 32'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      n++;
      if (!done && !busy) busy_ok = 1'b0;
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'(ref_edges(f, a, b)));
    check({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
    check({tag, "_result_held"}, 32'(hold_ok), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_result"}, result, ref_result(f, a, b));
    @(posedge clock); #1;
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] prev;
    bit saw_done;
    logic [4:0] funcs [4];
    logic [4:0] f;
    logic [31:0] a;
    logic [31:0] b;
    funcs[0] = ALU_DIV;
    funcs[1] = ALU_DIVU;
    funcs[2] = ALU_REM;
    funcs[3] = ALU_REMU;

    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Directed operations.
    run_op("div_100_7",   ALU_DIV,  32'd100, 32'd7, 1'b0);
    run_op("rem_100_7",   ALU_REM,  32'd100, 32'd7, 1'b0);
    run_op("div_m100_7",  ALU_DIV,  32'hFFFF_FF9C, 32'd7, 1'b0);
    run_op("rem_m100_7",  ALU_REM,  32'hFFFF_FF9C, 32'd7, 1'b0);
    run_op("divu_max_2",  ALU_DIVU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_op("div_5_0",     ALU_DIV,  32'd5, 32'd0, 1'b0);
    run_op("remu_5_0",    ALU_REMU, 32'd5, 32'd0, 1'b0);
    run_op("div_m5_0",    ALU_DIV,  32'hFFFF_FFFB, 32'd0, 1'b0);
    run_op("rem_m5_0",    ALU_REM,  32'hFFFF_FFFB, 32'd0, 1'b0);
    run_op("div_ovf",     ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("rem_ovf",     ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("divu_poke",   ALU_DIVU, 32'd1000, 32'd3, 1'b1);

    // Illegal function code is ignored.
    alu_function = 5'd0;
    operand_a = 32'd9;
    operand_b = 32'd3;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("illegal_func_idle", 32'(busy), 32'd0);

    // Flush mid-CALC: back to idle, no done, result unchanged.
    prev = result;
    alu_function = ALU_DIV;
    operand_a = 32'd1000;
    operand_b = 32'd9;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_done", 32'(done), 32'd0);
    check("flush_result", result, prev);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (done) saw_done = 1'b1;
    end
    check("flush_no_done", 32'(saw_done), 32'd0);
    run_op("after_flush", ALU_DIV, 32'd1000, 32'd9, 1'b0);

    // Flush wins over start in the same cycle.
    alu_function = ALU_DIVU;
    operand_a = 32'd50;
    operand_b = 32'd5;
    start = 1'b1;
    flush = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    flush = 1'b0;
    check("flush_over_start", 32'(busy), 32'd0);

    // Reset in the middle of CALC clears every output.
    alu_function = ALU_DIVU;
    operand_a = 32'd12345;
    operand_b = 32'd7;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    check("midreset_result", result, 32'd0);
    run_op("after_reset", ALU_REMU, 32'd12345, 32'd7, 1'b0);

    // Random operations with a bias toward the corner cases.
    for (int k = 0; k < 24; k++) begin
      f = funcs[$urandom_range(0, 3)];
      a = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: b = $urandom;
      endcase
      run_op("random", f, a, b, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
